// File: rtl/rep_seq_checker.sv
// rep_seq_checker
//   Hardware monitor for "rose(b) |-> b[->N] ##1 a" (mode=0, goto) and
//   "rose(b) |-> b[=N] ##1 a" (mode=1, non-consecutive). A rising edge of b
//   in IDLE starts one attempt; that b is occurrence 1. The result is
//   reported as registered one-cycle pass/fail pulses.
//
//   Parameters: N (1..15) required b count, MAX_WAIT (>=1) cycles allowed in
//   COUNT/WAIT_A before a timeout fail, CNT_W wait-counter width
//   (2**CNT_W > MAX_WAIT).
//
//   Ports:
//     clk      sampling clock (posedge)
//     rst      asynchronous active-high reset
//     b        repeated event
//     a        completion event
//     mode     0 = goto, 1 = non-consecutive; sampled only at the trigger
//     busy     attempt in progress
//     pass     one-cycle pulse, attempt succeeded
//     fail     one-cycle pulse, attempt failed
//     timeout  one-cycle pulse alongside fail when MAX_WAIT expired
//     b_count  b occurrences counted in the current/last attempt
//
//   Optional macro REP_CHK_STATS_EN adds saturating counters pass_cnt,
//   fail_cnt (16 bit) and drop_cnt (8 bit, b rises ignored while busy).
module rep_seq_checker #(
  parameter int N        = 2,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b,
  input  logic       a,
  input  logic       mode,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       timeout,
  output logic [3:0] b_count
`ifdef REP_CHK_STATS_EN
  ,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] WAIT_A = 2'd3;

  localparam logic [3:0]       N_VAL    = 4'(N);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [3:0]       b_count_q, b_count_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic             b_q;
  logic             rise;
  logic [3:0]       b_count_inc;

  assign rise        = b & ~b_q;
  assign b_count_inc = b_count_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    b_count_d = b_count_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          mode_d    = mode;
          b_count_d = 4'd1;
          wait_d    = '0;
          busy_d    = 1'b1;
          if (N == 1) state_d = mode ? WAIT_A : CHECK;
          else        state_d = COUNT;
        end
      end

      COUNT: begin
        // Reaching N on the expiry cycle still counts as progress.
        if (b && (b_count_inc == N_VAL)) begin
          b_count_d = b_count_inc;
          wait_d    = '0;
          state_d   = mode_q ? WAIT_A : CHECK;
        end else if (wait_q == WAIT_MAX) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          wait_d    = '0;
          state_d   = IDLE;
        end else begin
          if (b) b_count_d = b_count_inc;
          wait_d = wait_q + 1'b1;
        end
      end

      CHECK: begin
        pass_d  = a;
        fail_d  = ~a;
        busy_d  = 1'b0;
        wait_d  = '0;
        state_d = IDLE;
      end

      WAIT_A: begin
        if (a) begin
          pass_d  = 1'b1;
          busy_d  = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end else if (b) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          wait_d  = '0;
          state_d = IDLE;
        end else if (wait_q == WAIT_MAX) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          wait_d    = '0;
          state_d   = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        wait_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      b_count_q <= '0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      b_count_q <= b_count_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      b_q       <= b;
    end
  end

  assign busy    = busy_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;
  assign b_count = b_count_q;

`ifdef REP_CHK_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        rise_dropped;

  // A rise is dropped when the running attempt does not consume it as an
  // occurrence: COUNT counts it, WAIT_A with a=0 treats it as occurrence N+1.
  assign rise_dropped = rise && (state_q != IDLE) && (state_q != COUNT) &&
                        !((state_q == WAIT_A) && !a);

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pass_d && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 16'd1;
    if (fail_d && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + 16'd1;
    if (rise_dropped && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rep_seq_checker.sv
// Directed bench for rep_seq_checker with N=2, MAX_WAIT=16, CNT_W=5.
// Inputs change 1 ns after each posedge; outputs are sampled there too.
module tb_rep_seq_checker;

  logic       clk;
  logic       rst;
  logic       b;
  logic       a;
  logic       mode;
  logic       busy;
  logic       pass;
  logic       fail;
  logic       timeout;
  logic [3:0] b_count;
`ifdef REP_CHK_STATS_EN
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rep_seq_checker #(.N(2), .MAX_WAIT(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .b       (b),
    .a       (a),
    .mode    (mode),
    .busy    (busy),
    .pass    (pass),
    .fail    (fail),
    .timeout (timeout),
    .b_count (b_count)
`ifdef REP_CHK_STATS_EN
    ,
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive b/a for one cycle, then step past the next posedge.
  task automatic cyc(input logic bv, input logic av);
    b = bv;
    a = av;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_fail;
    rst = 1'b1; b = 1'b0; a = 1'b0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {29'd0, pass, fail, timeout}, 32'd0);
    chk("rst_bcount", {28'd0, b_count}, 32'd0);
    rst = 1'b0;

    // goto, b at 3 and 5, a at 6 -> pass
    mode = 1'b0;
    cyc(0, 0);
    cyc(1, 0);
    chk("s1_busy_trig", {31'd0, busy}, 32'd1);
    chk("s1_bcnt_trig", {28'd0, b_count}, 32'd1);
    cyc(0, 0);
    cyc(1, 0);
    chk("s1_bcnt2", {28'd0, b_count}, 32'd2);
    chk("s1_nopass_yet", {30'd0, pass, fail}, 32'd0);
    cyc(0, 1);
    chk("s1_pass", {29'd0, pass, fail, busy}, 32'b100);
    cyc(0, 0);
    chk("s1_pulse_end", {30'd0, pass, fail}, 32'd0);
    chk("s1_bcnt_hold", {28'd0, b_count}, 32'd2);

    // goto, a late -> fail without timeout, late a ignored
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    chk("s2_fail", {28'd0, pass, fail, timeout, busy}, 32'b0100);
    cyc(0, 0);
    chk("s2_fail_end", {31'd0, fail}, 32'd0);
    cyc(0, 0);
    cyc(0, 1);
    chk("s2_late_a", {29'd0, pass, fail, busy}, 32'd0);

    // non-consecutive, a long after the 2nd b -> pass
    mode = 1'b1;
    cyc(0, 0);
    cyc(1, 0);
    mode = 1'b0;  // mode only matters at the trigger
    cyc(0, 0);
    cyc(1, 0);
    repeat (6) cyc(0, 0);
    chk("s3_busy_wait", {29'd0, busy, pass, fail}, 32'b100);
    cyc(0, 1);
    chk("s3_pass", {29'd0, pass, fail, busy}, 32'b100);
    chk("s3_bcnt", {28'd0, b_count}, 32'd2);

    // non-consecutive, 3rd b before a -> fail, b_count stays 2
    mode = 1'b1;
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 0);
    chk("s4_fail", {28'd0, pass, fail, timeout, busy}, 32'b0100);
    chk("s4_bcnt", {28'd0, b_count}, 32'd2);
    cyc(0, 0);
    cyc(0, 1);
    chk("s4_late_a", {30'd0, pass, fail}, 32'd0);

    // non-consecutive, a never -> timeout 17 cycles after entering WAIT_A
    mode = 1'b1;
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 0);
    seen_fail = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0);
      seen_fail = seen_fail | fail | pass;
    end
    chk("s5_no_early", {31'd0, seen_fail}, 32'd0);
    cyc(0, 0);
    chk("s5_timeout", {28'd0, pass, fail, timeout, busy}, 32'b0110);
    cyc(0, 0);
    chk("s5_timeout_end", {30'd0, fail, timeout}, 32'd0);

    // goto, stuck in COUNT -> timeout, b_count stays 1
    mode = 1'b0;
    cyc(1, 0);
    seen_fail = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0);
      seen_fail = seen_fail | fail | pass;
    end
    chk("s6_no_early", {31'd0, seen_fail}, 32'd0);
    cyc(0, 0);
    chk("s6_timeout", {28'd0, pass, fail, timeout, busy}, 32'b0110);
    chk("s6_bcnt", {28'd0, b_count}, 32'd1);

    // consecutive b counts, back-to-back trigger after pass, busy rise counted
    mode = 1'b0;
    cyc(1, 0);
    cyc(1, 0);
    chk("s7_bcnt_consec", {28'd0, b_count}, 32'd2);
    cyc(0, 1);
    chk("s7_pass", {30'd0, pass, busy}, 32'b10);
    cyc(1, 0);
    chk("s7_b2b_trig", {27'd0, busy, b_count}, {27'd0, 1'b1, 4'd1});
    cyc(0, 0);
    cyc(1, 0);
    chk("s7_no_restart", {28'd0, b_count}, 32'd2);
    cyc(0, 0);
    chk("s7_fail", {30'd0, pass, fail}, 32'b01);

    // non-consecutive, a and b together in WAIT_A -> pass
    mode = 1'b1;
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(1, 1);
    chk("s8_pass_ab", {30'd0, pass, fail}, 32'b10);

    // async reset mid-COUNT discards attempt
    mode = 1'b0;
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    chk("s9_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("s9_rst_async", {27'd0, busy, pass, fail, timeout, (b_count != 4'd0)}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1);
    chk("s9_after_rst", {29'd0, pass, fail, timeout}, 32'd0);
    chk("s9_new_trig", {27'd0, busy, b_count}, {27'd0, 1'b1, 4'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
